// File: rtl/uart_word_loader.sv
// uart_word_loader: assembles received UART bytes MSB-first into 32-bit words and
// writes them sequentially through a single write port. Partial words are dropped on timeout or rx_err.
module uart_word_loader #(
  parameter int NUM_WORDS      = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_rx_err,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [31:0]       o_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_words_loaded,
  output logic              o_timeout_err,
  output logic              o_frame_err
);
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W+1)'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            r_state, w_state_next;
  logic [1:0]        r_byte_cnt, w_byte_cnt_next, w_cnt_base;
  logic [ADDR_W-1:0] r_word_idx, w_word_idx_next;
  logic [31:0]       r_shift, w_shift_next;
  logic [GAP_W-1:0]  r_gap, w_gap_next;
  logic              r_we, w_we_next;
  logic [ADDR_W-1:0] r_waddr, w_waddr_next;
  logic [31:0]       r_wdata, w_wdata_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic [ADDR_W:0]   r_words_loaded, w_words_loaded_next;
  logic              r_timeout_err, w_timeout_err_next;
  logic              r_frame_err, w_frame_err_next;
  logic              w_final;

  always_comb begin
    w_state_next        = r_state;
    w_byte_cnt_next     = r_byte_cnt;
    w_cnt_base          = r_byte_cnt;
    w_word_idx_next     = r_word_idx;
    w_shift_next        = r_shift;
    w_gap_next          = r_gap;
    w_we_next           = 1'b0;
    w_waddr_next        = r_waddr;
    w_wdata_next        = r_wdata;
    w_done_next         = r_done;
    w_words_loaded_next = r_words_loaded;
    w_timeout_err_next  = r_timeout_err;
    w_frame_err_next    = r_frame_err;
    w_final             = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_state_next        = RECV;
          w_byte_cnt_next     = 2'd0;
          w_word_idx_next     = '0;
          w_shift_next        = 32'd0;
          w_gap_next          = '0;
          w_done_next         = 1'b0;
          w_words_loaded_next = '0;
          w_timeout_err_next  = 1'b0;
          w_frame_err_next    = 1'b0;
        end
      end
      RECV, WRITE: begin
        if (r_state == WRITE) begin
          w_word_idx_next     = r_word_idx + 1'b1;
          w_words_loaded_next = r_words_loaded + 1'b1;
          w_state_next        = RECV;
          w_final             = (r_words_loaded == LAST_WORD);
        end
        if (w_final) begin
          w_state_next = DONE;
          w_done_next  = 1'b1;
        end else begin
          // Timeout is evaluated first so a byte on the expiry edge starts a fresh word.
          if (r_byte_cnt != 2'd0) begin
            if (r_gap == GAP_LAST) begin
              w_cnt_base         = 2'd0;
              w_gap_next         = '0;
              w_timeout_err_next = 1'b1;
            end else begin
              w_gap_next = r_gap + 1'b1;
            end
          end
          w_byte_cnt_next = w_cnt_base;
          if (i_rx_err) begin
            w_byte_cnt_next  = 2'd0;
            w_gap_next       = '0;
            w_frame_err_next = 1'b1;
          end else if (i_rx_valid) begin
            w_shift_next = {r_shift[23:0], i_rx_data};
            w_gap_next   = '0;
            if (w_cnt_base == 2'd3) begin
              w_byte_cnt_next = 2'd0;
              w_state_next    = WRITE;
              w_we_next       = 1'b1;
              w_waddr_next    = w_word_idx_next;
              w_wdata_next    = {r_shift[23:0], i_rx_data};
            end else begin
              w_byte_cnt_next = w_cnt_base + 2'd1;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    w_busy_next = (w_state_next == RECV) || (w_state_next == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_byte_cnt     <= 2'd0;
      r_word_idx     <= '0;
      r_shift        <= 32'd0;
      r_gap          <= '0;
      r_we           <= 1'b0;
      r_waddr        <= '0;
      r_wdata        <= 32'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_words_loaded <= '0;
      r_timeout_err  <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_byte_cnt     <= w_byte_cnt_next;
      r_word_idx     <= w_word_idx_next;
      r_shift        <= w_shift_next;
      r_gap          <= w_gap_next;
      r_we           <= w_we_next;
      r_waddr        <= w_waddr_next;
      r_wdata        <= w_wdata_next;
      r_busy         <= w_busy_next;
      r_done         <= w_done_next;
      r_words_loaded <= w_words_loaded_next;
      r_timeout_err  <= w_timeout_err_next;
      r_frame_err    <= w_frame_err_next;
    end
  end

  assign o_we           = r_we;
  assign o_waddr        = r_waddr;
  assign o_wdata        = r_wdata;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_words_loaded = r_words_loaded;
  assign o_timeout_err  = r_timeout_err;
  assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: drives byte streams into uart_word_loader and compares every
// write against a byte-level reference model through a scoreboard queue.
module tb_uart_word_loader;
  localparam int NUM_WORDS = 32;
  localparam int ADDR_W    = 5;
  localparam int TIMEOUT   = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rxData = 8'd0;
  logic              rxValid = 1'b0;
  logic              rxErr = 1'b0;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wordsLoaded;
  logic              timeoutErr;
  logic              frameErr;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: a load is a list of accepted bytes; words are whole groups of four.
  logic [ADDR_W-1:0] expAddr[$];
  logic [31:0]       expData[$];
  logic [7:0]        mPart[$];
  bit                mActive, mDone, mFinalWrite, mTerr, mFerr;
  int                mWords, mSince;

  uart_word_loader #(.NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_rx_data(rxData), .i_rx_valid(rxValid),
    .i_rx_err(rxErr), .o_we(we), .o_waddr(waddr), .o_wdata(wdata), .o_busy(busy),
    .o_done(done), .o_words_loaded(wordsLoaded), .o_timeout_err(timeoutErr),
    .o_frame_err(frameErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelClear();
    mActive = 0; mDone = 0; mFinalWrite = 0; mTerr = 0; mFerr = 0;
    mWords = 0; mSince = 0;
    mPart.delete();
  endtask

  // One clock edge of the model with the inputs the DUT samples on that edge.
  task automatic modelEdge(input bit v, input logic [7:0] d, input bit e, input bit s);
    if (mFinalWrite) begin
      mFinalWrite = 0; mDone = 1; mActive = 0;
    end else if (!mActive) begin
      if (s) begin
        modelClear();
        mActive = 1;
      end
    end else begin
      if (mPart.size() > 0 && mSince + 1 >= TIMEOUT) begin
        mPart.delete();
        mTerr = 1;
      end
      if (e) begin
        mPart.delete(); mFerr = 1; mSince = 0;
      end else if (v) begin
        mPart.push_back(d);
        mSince = 0;
        if (mPart.size() == 4) begin
          expAddr.push_back(ADDR_W'(mWords));
          expData.push_back({mPart[0], mPart[1], mPart[2], mPart[3]});
          mPart.delete();
          mWords++;
          if (mWords == NUM_WORDS) mFinalWrite = 1;
        end
      end else begin
        mSince++;
      end
    end
  endtask

  // Called just after a rising edge; holds the inputs across the next edge.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit e, input bit s);
    rxValid = v; rxData = d; rxErr = e; start = s;
    modelEdge(v, d, e, s);
    @(posedge clk); #1;
    rxValid = 1'b0; rxErr = 1'b0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0);
  endtask

  task automatic sendByte(input logic [7:0] d, input int gap);
    idle(gap);
    applyStimulus(1, d, 0, 0);
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) sendByte(w[i*8 +: 8], gap);
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, "_done"}, done, mDone);
    checkOutput({tag, "_busy"}, busy, mActive);
    checkOutput({tag, "_wordsLoaded"}, wordsLoaded, mWords);
    checkOutput({tag, "_timeoutErr"}, timeoutErr, mTerr);
    checkOutput({tag, "_frameErr"}, frameErr, mFerr);
    checkOutput({tag, "_sbEmpty"}, expAddr.size(), 0);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && we === 1'b1) begin
      if (expAddr.size() == 0) begin
        checkOutput("unexpectedWe", {27'd0, waddr}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("waddr", waddr, expAddr.pop_front());
        checkOutput("wdata", wdata, expData.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [32:0] pat;
    modelClear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("rst_we", we, 0);
    checkOutput("rst_waddr", waddr, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wordsLoaded", wordsLoaded, 0);
    checkOutput("rst_flags", {timeoutErr, frameErr}, 0);

    // Bytes with no load armed must not produce writes.
    sendWord(32'h1234_5678, 0);
    idle(2);
    checkOutput("idle_busy", busy, 0);

    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("start_busy", busy, 1);

    sendByte(8'hDE, 0); sendByte(8'hAD, 0); sendByte(8'hBE, 0); sendByte(8'hEF, 0);
    checkOutput("b2b_we", we, 1);
    checkOutput("b2b_waddr", waddr, 0);
    checkOutput("b2b_wdata", wdata, 32'hDEAD_BEEF);
    sendByte(8'h01, 0);
    applyStimulus(0, 8'h00, 0, 1);
    sendByte(8'h02, 0); sendByte(8'h03, 0); sendByte(8'h04, 0);
    idle(2);
    checkOutput("startInRecv_busy", busy, 1);
    checkOutput("b2b_wordsLoaded", wordsLoaded, 2);

    sendByte(8'h11, 2); sendByte(8'h22, 2);
    idle(150);
    checkOutput("timeout_flag", timeoutErr, 1);
    sendWord(32'h0102_0304, 1);

    sendByte(8'hA1, 3); sendByte(8'hA2, TIMEOUT - 2); sendByte(8'hA3, 0); sendByte(8'hA4, 0);
    sendByte(8'hB1, 3); sendByte(8'hB2, TIMEOUT - 1); sendByte(8'hB3, 0); sendByte(8'hB4, 0);
    sendByte(8'hB5, 0);

    sendByte(8'hAA, 1);
    idle(1);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("frame_flag", frameErr, 1);
    sendWord(32'h1234_5678, 1);
    sendByte(8'h9A, 1);
    applyStimulus(1, 8'hFF, 1, 0);
    sendByte(8'hBC, 0); sendByte(8'hDE, 0); sendByte(8'hF0, 0);

    while (mWords < NUM_WORDS) begin
      if ($urandom_range(0, 24) == 0) begin
        idle($urandom_range(1, 4));
        applyStimulus(0, 8'h00, 1, 0);
      end else begin
        sendByte(8'($urandom), ($urandom_range(0, 19) == 0) ? 150 : $urandom_range(0, 12));
      end
    end
    applyStimulus(1, 8'h5A, 0, 0);
    idle(3);
    checkAgainstModel("load1");
    checkOutput("load1_doneConst", done, 1);
    checkOutput("load1_words32", wordsLoaded, NUM_WORDS);

    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("restart_done", done, 0);
    checkOutput("restart_wordsLoaded", wordsLoaded, 0);
    checkOutput("restart_flags", {timeoutErr, frameErr}, 0);
    checkOutput("restart_busy", busy, 1);
    for (int i = 0; i < NUM_WORDS; i++) begin
      pat = (33'd1 << (i + 1)) - 33'd1;
      sendWord(pat[31:0], 10);
    end
    idle(3);
    checkAgainstModel("load2");
    checkOutput("load2_done", done, 1);
    checkOutput("load2_words32", wordsLoaded, NUM_WORDS);
    checkOutput("load2_lastData", wdata, 32'hFFFF_FFFF);
    checkOutput("load2_lastAddr", waddr, NUM_WORDS - 1);
    checkOutput("load2_flags", {timeoutErr, frameErr}, 0);

    applyStimulus(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) sendWord($urandom, $urandom_range(0, 3));
    sendByte(8'h77, 1); sendByte(8'h88, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRst_we", we, 0);
    checkOutput("midRst_waddr", waddr, 0);
    checkOutput("midRst_wdata", wdata, 0);
    checkOutput("midRst_busy", busy, 0);
    checkOutput("midRst_wordsLoaded", wordsLoaded, 0);
    checkOutput("midRst_sbEmpty", expAddr.size(), 0);
    modelClear();
    expAddr.delete(); expData.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 8'h00, 0, 1);
    sendWord(32'hCAFE_F00D, 2);
    idle(3);
    checkAgainstModel("reload");
    checkOutput("reload_addr", waddr, 0);
    checkOutput("reload_data", wdata, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
